// File: rtl/pwm_bank_pkg.sv
// Shared definitions for the multi-channel PWM bank: register map offsets,
// ctrl bit positions and the counting-mode / direction encodings.
package pwm_bank_pkg;

  localparam int DUTY_BASE   = 0;
  localparam int CTRL_OUT_EN = 0;
  localparam int CTRL_PWM_EN = 1;

  typedef enum logic {
    MODE_EDGE   = 1'b0,
    MODE_CENTRE = 1'b1
  } pwm_mode_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } cnt_dir_e;

  // Register map: duties, then ctrl words, then the three global registers.
  function automatic int CTRL_BASE(input int num_ch);
    return num_ch;
  endfunction

  function automatic int TOP_ADDR(input int num_ch);
    return 2 * num_ch;
  endfunction

  function automatic int PRE_ADDR(input int num_ch);
    return 2 * num_ch + 1;
  endfunction

  function automatic int MODE_ADDR(input int num_ch);
    return 2 * num_ch + 2;
  endfunction

endpackage

// File: rtl/pwm_bank_multi_timebase.sv
// Shared timebase: prescaler, edge/centre up-down counter and the period
// boundary strobe that loads every shadow register in the bank.
module pwm_timebase
  import pwm_bank_pkg::*;
#(
  parameter int RES   = 8,
  parameter int PRE_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [PRE_W-1:0] prescale,
  input  logic [RES-1:0]   top_active,
  input  logic             mode_centre,
  output logic [RES-1:0]   cnt,
  output logic             load,
  output logic             period_tick
);

  logic [PRE_W-1:0] pre_cnt;
  logic             tick;
  logic             wrap;
  logic [RES-1:0]   cnt_next;
  cnt_dir_e         dir, dir_next;

  // The >= lets a freshly reduced prescale take hold without a long rollover.
  assign tick = (pre_cnt >= prescale);
  assign load = tick & wrap;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_cnt     <= '0;
      cnt         <= '0;
      dir         <= DIR_UP;
      period_tick <= 1'b0;
    end else begin
      period_tick <= load;
      pre_cnt     <= tick ? '0 : pre_cnt + 1'b1;
      if (tick) begin
        cnt <= cnt_next;
        dir <= dir_next;
      end
    end
  end

  // Every boundary leaves cnt = 0 and dir = up, which also covers a mode switch.
  always_comb begin
    cnt_next = cnt;
    dir_next = dir;
    wrap     = 1'b0;
    if (!mode_centre) begin
      dir_next = DIR_UP;
      if (cnt >= top_active) begin
        cnt_next = '0;
        wrap     = 1'b1;
      end else begin
        cnt_next = cnt + 1'b1;
      end
    end else if (top_active == '0) begin
      cnt_next = '0;
      dir_next = DIR_UP;
      wrap     = 1'b1;
    end else if (dir == DIR_UP && cnt < top_active) begin
      cnt_next = cnt + 1'b1;
    end else begin
      cnt_next = cnt - 1'b1;
      if (cnt == RES'(1)) begin
        wrap     = 1'b1;
        dir_next = DIR_UP;
      end else begin
        dir_next = DIR_DOWN;
      end
    end
  end

endmodule

// File: rtl/pwm_bank_multi.sv
// NUM_CH-channel PWM bank with double-buffered duty/top/mode, shared
// prescaled timebase and per-channel output enable / static-high control.
module pwm_bank_multi
  import pwm_bank_pkg::*;
#(
  parameter int NUM_CH = 16,
  parameter int RES    = 8,
  parameter int PRE_W  = 8,
  parameter int ADDR_W = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [RES-1:0]    wr_data,
  output logic [NUM_CH-1:0] pwm_out,
  output logic              period_tick
);

  localparam logic [ADDR_W-1:0] TOP_A  = ADDR_W'(TOP_ADDR(NUM_CH));
  localparam logic [ADDR_W-1:0] PRE_A  = ADDR_W'(PRE_ADDR(NUM_CH));
  localparam logic [ADDR_W-1:0] MODE_A = ADDR_W'(MODE_ADDR(NUM_CH));

  logic [RES-1:0]    duty_shadow [NUM_CH];
  logic [RES-1:0]    duty_active [NUM_CH];
  logic [1:0]        ctrl        [NUM_CH];
  logic [RES-1:0]    top_shadow, top_active;
  logic [PRE_W-1:0]  prescale;
  pwm_mode_e         mode_shadow, mode_active;
  logic [RES-1:0]    cnt;
  logic              load;
  logic [NUM_CH-1:0] out_next;

  pwm_timebase #(.RES(RES), .PRE_W(PRE_W)) u_timebase (
    .clk         (clk),
    .rst         (rst),
    .prescale    (prescale),
    .top_active  (top_active),
    .mode_centre (mode_active == MODE_CENTRE),
    .cnt         (cnt),
    .load        (load),
    .period_tick (period_tick)
  );

  // Active copies read the old shadow on a boundary, so a coincident write
  // only reaches the shadow and waits for the following boundary.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int n = 0; n < NUM_CH; n++) begin
        duty_shadow[n] <= '0;
        duty_active[n] <= '0;
        ctrl[n]        <= '0;
      end
      top_shadow  <= '1;
      top_active  <= '1;
      prescale    <= '0;
      mode_shadow <= MODE_EDGE;
      mode_active <= MODE_EDGE;
    end else begin
      if (load) begin
        for (int n = 0; n < NUM_CH; n++) duty_active[n] <= duty_shadow[n];
        top_active  <= top_shadow;
        mode_active <= mode_shadow;
      end
      if (wr_en) begin
        for (int n = 0; n < NUM_CH; n++) begin
          if (wr_addr == ADDR_W'(DUTY_BASE + n)) duty_shadow[n] <= wr_data;
          if (wr_addr == ADDR_W'(CTRL_BASE(NUM_CH) + n)) ctrl[n] <= wr_data[1:0];
        end
        if (wr_addr == TOP_A)  top_shadow  <= wr_data;
        if (wr_addr == PRE_A)  prescale    <= PRE_W'(wr_data);
        if (wr_addr == MODE_A) mode_shadow <= pwm_mode_e'(wr_data[0]);
      end
    end
  end

  for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
    assign out_next[n] = ctrl[n][CTRL_OUT_EN] &
                         (~ctrl[n][CTRL_PWM_EN] | (cnt < duty_active[n]));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pwm_out <= '0;
    else     pwm_out <= out_next;
  end

endmodule

// File: tb/tb_pwm_bank_multi.sv
// Directed bench for pwm_bank_multi (16 channels, 8-bit): reset defaults,
// edge/centre waveforms, double buffering, boundary duties, async reset.
module tb_pwm_bank_multi;

  localparam int NUM_CH = 16;
  localparam int RES    = 8;
  localparam int PRE_W  = 8;
  localparam int ADDR_W = 7;

  logic              clk = 1'b0;
  logic              rst;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [RES-1:0]    wr_data;
  logic [NUM_CH-1:0] pwm_out;
  logic              period_tick;

  int tests_run    = 0;
  int tests_failed = 0;

  int          highs, ticks, n;
  logic [31:0] pat;

  always #5 clk = ~clk;

  pwm_bank_multi #(.NUM_CH(NUM_CH), .RES(RES), .PRE_W(PRE_W), .ADDR_W(ADDR_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .pwm_out     (pwm_out),
    .period_tick (period_tick)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    tests_run++;
    if (observed !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Called at a negedge; the write is captured on the following posedge.
  task automatic applyStimulus(input logic [ADDR_W-1:0] addr, input logic [RES-1:0] data);
    wr_en   = 1'b1;
    wr_addr = addr;
    wr_data = data;
    @(negedge clk);
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
  endtask

  task automatic waitTick(input string tag);
    int cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!period_tick && cyc < 600);
    checkOutput(tag, 32'(period_tick), 32'd1);
  endtask

  task automatic sampleWindow(input int ch, input int nclk, output int hi,
                              output int tk, output logic [31:0] p);
    hi = 0;
    tk = 0;
    p  = '0;
    for (int i = 0; i < nclk; i++) begin
      hi += int'(pwm_out[ch]);
      tk += int'(period_tick);
      p   = {p[30:0], pwm_out[ch]};
      @(negedge clk);
    end
  endtask

  initial begin
    rst     = 1'b1;
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    repeat (3) @(negedge clk);
    checkOutput("reset_pwm_out", 32'(pwm_out), 32'h0);
    checkOutput("reset_period_tick", 32'(period_tick), 32'h0);
    rst = 1'b0;
    @(negedge clk);

    // Static high on channel 3, one clk after the ctrl write.
    applyStimulus(7'd19, 8'h01);
    checkOutput("ctrl3_same_clk", 32'(pwm_out), 32'h0);
    @(negedge clk);
    checkOutput("ctrl3_static_high", 32'(pwm_out), 32'h0008);

    // Edge mode, top 9, duty 3: 0111000000 from the tick cycle.
    applyStimulus(7'd0, 8'd3);
    applyStimulus(7'd16, 8'h03);
    applyStimulus(7'd32, 8'd9);
    waitTick("edge_first_load");
    sampleWindow(0, 10, highs, ticks, pat);
    checkOutput("edge_pattern", pat, 32'h1C0);
    checkOutput("edge_high_clks", 32'(highs), 32'd3);
    checkOutput("edge_ticks_in_period", 32'(ticks), 32'd1);
    checkOutput("edge_period_10", 32'(period_tick), 32'd1);
    checkOutput("edge_ch3_still_high", 32'(pwm_out[3]), 32'd1);

    // Mid-period duty change 3 -> 7 waits for the next boundary.
    applyStimulus(7'd0, 8'd7);
    sampleWindow(0, 9, highs, ticks, pat);
    checkOutput("midwrite_old_duty", pat, 32'h1C0);
    checkOutput("midwrite_tick_align", 32'(period_tick), 32'd1);
    sampleWindow(0, 10, highs, ticks, pat);
    checkOutput("midwrite_new_duty", pat, 32'h1FC);
    checkOutput("midwrite_new_highs", 32'(highs), 32'd7);

    // Boundary duties on channel 2.
    applyStimulus(7'd18, 8'h03);
    sampleWindow(2, 20, highs, ticks, pat);
    checkOutput("duty0_const_low", 32'(highs), 32'd0);
    applyStimulus(7'd2, 8'd10);
    waitTick("duty10_load");
    @(negedge clk);
    sampleWindow(2, 20, highs, ticks, pat);
    checkOutput("duty10_const_high", 32'(highs), 32'd20);

    // Unmapped write must leave every register untouched.
    applyStimulus(7'h7F, 8'h00);
    waitTick("unmapped_tick");
    sampleWindow(0, 20, highs, ticks, pat);
    checkOutput("unmapped_ch0_highs", 32'(highs), 32'd14);
    checkOutput("unmapped_ticks", 32'(ticks), 32'd2);
    sampleWindow(2, 20, highs, ticks, pat);
    checkOutput("unmapped_ch2_highs", 32'(highs), 32'd20);
    checkOutput("unmapped_ch3", 32'(pwm_out[3]), 32'd1);

    // Centre mode, top 4, prescale 1, duty 2: 16-clk period.
    applyStimulus(7'd17, 8'h03);
    applyStimulus(7'd1, 8'd2);
    applyStimulus(7'd32, 8'd4);
    applyStimulus(7'd34, 8'd1);
    applyStimulus(7'd33, 8'd1);
    waitTick("centre_wait1");
    waitTick("centre_wait2");
    waitTick("centre_wait3");
    sampleWindow(1, 16, highs, ticks, pat);
    checkOutput("centre_pattern", pat, 32'hF801);
    checkOutput("centre_high_clks", 32'(highs), 32'd6);
    checkOutput("centre_ticks_in_period", 32'(ticks), 32'd1);
    checkOutput("centre_period_16", 32'(period_tick), 32'd1);

    // Asynchronous reset with outputs high, then reset-value period of 256.
    checkOutput("pre_reset_ch3_high", 32'(pwm_out[3]), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("async_reset_out", 32'(pwm_out), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!period_tick && n < 600);
    checkOutput("reset_period_256", 32'(n), 32'd256);
    checkOutput("reset_ctrl_cleared", 32'(pwm_out), 32'h0);
    applyStimulus(7'd16, 8'h03);
    sampleWindow(0, 20, highs, ticks, pat);
    checkOutput("reset_duty_cleared", 32'(highs), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
